irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller on the picorv32 native memory bus (responder, alongside sram_simple).
- Drives the core's `irq` inputs and consumes the core's `eoi` outputs, i.e. it is the far end of the core's IRQ/EOI interface.
- Synchronizes external sources, latches edge- or level-type requests into a pending register, masks them with an enable register, and clears pending bits when the core acknowledges by entering the handler.

Parameters:
- N, 16: number of interrupt sources (1..32).
- BASE_ADDR, 32'h1000_0000: base of the register window.
- WIN_BITS, 8: window size is 2**WIN_BITS bytes.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- src  input  N  asynchronous external interrupt sources
- irq_out  output  N  interrupt requests to core irq[N-1:0]
- eoi  input  N  core eoi[N-1:0]; high while the handler for that bit runs
- mem_valid  input  1  core bus request valid
- mem_addr  input  32  byte address
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte strobes; 0 = read
- mem_rdata  output  32  read data, valid only while mem_ready=1
- mem_ready  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rstn=0): sync flops, src_prev, eoi_prev, PENDING, ENABLE, MODE = 0; irq_out=0, mem_ready=0, mem_rdata=0. A transaction in flight is dropped; mem_ready is forced low immediately.
- Synchronizer: 2-flop sync per src bit → s. src_prev = registered s. rise = s & ~src_prev.
- Set condition per bit i:
  - MODE[i]=1 (edge): set on rise[i].
  - MODE[i]=0 (level): set every cycle s[i]=1.
  - FORCE write also sets (W1S).
- Clear condition per bit i:
  - eoi rising edge (eoi[i] & ~eoi_prev[i]), i.e. the core entered the handler.
  - PENDING W1C write.
- Set and clear in the same cycle: set wins; no event is lost.
  - Level source still high after clear is re-pended next cycle.
  - Edge arriving during a handler stays pending and is re-raised after retirq.
- irq_out = PENDING & ENABLE, registered. Request-to-irq_out latency = 4 cycles worst case (2 sync + edge/pend + output reg).
- Address hit: mem_valid & (mem_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]). Offset = mem_addr[WIN_BITS-1:0], word aligned; addr[1:0] ignored.
- Handshake:
  - On hit & ~mem_ready: mem_ready=1 the next cycle for exactly one cycle.
  - The core holds the request until ready, so back-to-back accesses take 2 cycles each.
  - No hit: mem_ready=0, mem_rdata=0.
- mem_rdata is registered with mem_ready and returns 0 in all other cycles (the SoC ORs/muxes it).
- Writes take effect on the cycle mem_ready is asserted, per byte lane (mem_wstrb[k] gates bits 8k+7:8k).
- Register map (bits ≥ N read 0 and ignore writes):
  - 0x00 PENDING: R, W1C.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C RAW: R; synchronized s.
  - 0x10 FORCE: W1S into PENDING; reads 0.
  - Other offsets in the window: read 0, writes ignored, mem_ready still returned.
- Unaffected by bus traffic: source capture continues during bus accesses; a W1C and a new edge in the same cycle leaves the bit set.

Test Plan:
- Reset with src=16'hFFFF → irq_out=0, mem_ready=0; read 0x00 after release with MODE=0, ENABLE=0 → PENDING=16'hFFFF, irq_out=0.
- Write ENABLE=0x0001, MODE=0x0001; pulse src[0] high 1 cycle → irq_out[0]=1 within 4 cycles; raise eoi[0] → irq_out[0]=0 two cycles later; src[0] low, so it stays 0.
- Edge mode: src[3] rises while eoi[3]=1 (handler active) → PENDING[3] stays 1, irq_out[3]=1 persists after eoi[3] falls.
- Write 0x10 with wdata=0x0000_8000, wstrb=4'b0010 → PENDING[15]=1; then W1C 0x00 with wdata=0x8000, wstrb=4'b0001 → bit unchanged (lane 1 not strobed); with wstrb=4'b0011 → cleared.
- Read 0x20 (unmapped) → mem_ready pulse, rdata=0; access to BASE_ADDR+0x100 → no mem_ready; mem_valid held with hit → mem_ready high 1 cycle, then low 1 cycle, then high.
- Assert rstn=0 in the cycle after mem_valid hit → mem_ready=0 that cycle; all registers 0 after release.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// picorv32 native memory bus as seen by a responder.
// The core drives the master side; irq_ctrl sits on the slave side.
interface irq_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes sources, latches edge/level
// requests into PENDING, masks with ENABLE and retires on the core's eoi rise.
module irq_ctrl #(
    parameter int          N         = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          WIN_BITS  = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] src,
    output logic [N-1:0] irq_out,
    input  logic [N-1:0] eoi,
    irq_ctrl_if.slave    bus
);

    localparam logic [WIN_BITS-1:0] OFF_PEND  = WIN_BITS'(32'h00);
    localparam logic [WIN_BITS-1:0] OFF_EN    = WIN_BITS'(32'h04);
    localparam logic [WIN_BITS-1:0] OFF_MODE  = WIN_BITS'(32'h08);
    localparam logic [WIN_BITS-1:0] OFF_RAW   = WIN_BITS'(32'h0C);
    localparam logic [WIN_BITS-1:0] OFF_FORCE = WIN_BITS'(32'h10);

    logic [N-1:0] sync1, s, src_prev, eoi_prev;
    logic [N-1:0] pending, enable, mode;
    logic [N-1:0] rise, eoi_rise, set_vec, clr_vec;
    logic [N-1:0] wbits, lane_n;
    logic [31:0]  lane_mask, wbits32, rd_word, rdata_q;
    logic         ready_q;
    logic         hit, access, wr, rd;
    logic [WIN_BITS-1:0] off;
    logic sel_pend, sel_en, sel_mode, sel_raw, sel_force;

    assign hit    = bus.mem_valid && (bus.mem_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign access = hit && !ready_q;
    assign wr     = access && (bus.mem_wstrb != 4'b0000);
    assign rd     = access && (bus.mem_wstrb == 4'b0000);
    assign off    = {bus.mem_addr[WIN_BITS-1:2], 2'b00};

    assign sel_pend  = (off == OFF_PEND);
    assign sel_en    = (off == OFF_EN);
    assign sel_mode  = (off == OFF_MODE);
    assign sel_raw   = (off == OFF_RAW);
    assign sel_force = (off == OFF_FORCE);

    assign lane_mask = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                        {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
    assign wbits32   = bus.mem_wdata & lane_mask;
    assign wbits     = wbits32[N-1:0];
    assign lane_n    = lane_mask[N-1:0];

    // Set wins over clear so an edge coinciding with eoi or W1C is never lost.
    assign rise     = s & ~src_prev;
    assign eoi_rise = eoi & ~eoi_prev;
    assign set_vec  = (mode & rise) | (~mode & s) | ({N{wr && sel_force}} & wbits);
    assign clr_vec  = eoi_rise | ({N{wr && sel_pend}} & wbits);

    always_comb begin
        rd_word = '0;
        if (sel_pend)
            rd_word[N-1:0] = pending;
        else if (sel_en)
            rd_word[N-1:0] = enable;
        else if (sel_mode)
            rd_word[N-1:0] = mode;
        else if (sel_raw)
            rd_word[N-1:0] = s;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1    <= '0;
            s        <= '0;
            src_prev <= '0;
            eoi_prev <= '0;
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            irq_out  <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            sync1    <= src;
            s        <= sync1;
            src_prev <= s;
            eoi_prev <= eoi;
            pending  <= (pending & ~clr_vec) | set_vec;
            irq_out  <= pending & enable;
            if (wr && sel_en)
                enable <= (enable & ~lane_n) | wbits;
            if (wr && sel_mode)
                mode <= (mode & ~lane_n) | wbits;
            ready_q  <= access;
            rdata_q  <= rd ? rd_word : '0;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[1:0], wbits32, lane_mask};

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register vector table through a read scoreboard, plus
// hand sequences for interrupt latency, eoi retire, lanes, handshake and reset.
module tb_irq_ctrl;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] src;
    logic [15:0] eoi;
    logic [15:0] irq_out;

    irq_ctrl_if bus_if();

    irq_ctrl #(.N(16), .BASE_ADDR(B), .WIN_BITS(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .src     (src),
        .irq_out (irq_out),
        .eoi     (eoi),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] src;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        bit          chk;
        int          id;
    } sb_t;

    vec_t vecs[11];
    sb_t  sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; returns just after the negedge that saw ready.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp, input int id);
        sb_t e;
        bit  got;
        e.exp = exp;
        e.chk = (wstrb == 4'b0000);
        e.id  = id;
        sbq.push_back(e);
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        bus_if.mem_wstrb = wstrb;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus_if.mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        bus_if.mem_valid = 1'b0;
        bus_if.mem_wstrb = 4'b0000;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL xfer%0d_timeout: got no ready expected ready", id);
            void'(sbq.pop_front());
        end else if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL xfer%0d_sb: got ready expected empty scoreboard", id);
        end else begin
            e = sbq.pop_front();
            if (e.chk)
                check($sformatf("xfer%0d_rdata", e.id), bus_if.mem_rdata, e.exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int lat;
        int seen;
        logic [3:0] hold_exp;

        vecs[0]  = '{16'h0000, B + 32'h04, 32'hFFFF_A5A5, 4'b1111, 32'h0};
        vecs[1]  = '{16'h0000, B + 32'h04, 32'h0,         4'b0000, 32'h0000_A5A5};
        vecs[2]  = '{16'h0000, B + 32'h04, 32'h0000_FF00, 4'b0010, 32'h0};
        vecs[3]  = '{16'h0000, B + 32'h04, 32'h0,         4'b0000, 32'h0000_FFA5};
        vecs[4]  = '{16'h0000, B + 32'h08, 32'h0000_1234, 4'b0001, 32'h0};
        vecs[5]  = '{16'h0000, B + 32'h08, 32'h0,         4'b0000, 32'h0000_0034};
        vecs[6]  = '{16'h0000, B + 32'h10, 32'h0,         4'b0000, 32'h0};
        vecs[7]  = '{16'h0F0F, B + 32'h0C, 32'h0,         4'b0000, 32'h0000_0F0F};
        vecs[8]  = '{16'h0F0F, B + 32'h0F, 32'h0,         4'b0000, 32'h0000_0F0F};
        vecs[9]  = '{16'h0F0F, B + 32'h20, 32'h0,         4'b0000, 32'h0};
        vecs[10] = '{16'h0000, B + 32'h04, 32'h0,         4'b1111, 32'h0};

        rstn = 1'b0;
        src  = 16'hFFFF;
        eoi  = '0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_addr  = '0;
        bus_if.mem_wdata = '0;
        bus_if.mem_wstrb = '0;

        // Reset with all sources high, then level sources pend after release.
        waitc(4);
        check("rst_irq_out", 32'(irq_out), 32'h0);
        check("rst_ready", 32'(bus_if.mem_ready), 32'h0);
        rstn = 1'b1;
        waitc(4);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0000_FFFF, 0);
        check("rst_pend_irq_out", 32'(irq_out), 32'h0);

        for (int i = 0; i < 11; i++) begin
            src = vecs[i].src;
            waitc(3);
            bus_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp, 10 + i);
        end

        src = '0;
        bus_xfer(B + 32'h08, 32'h0, 4'b1111, 32'h0, 30);
        waitc(4);
        bus_xfer(B + 32'h00, 32'hFFFF_FFFF, 4'b1111, 32'h0, 31);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0, 32);

        // Edge source, one-cycle pulse, retired by eoi.
        bus_xfer(B + 32'h04, 32'h0000_0001, 4'b1111, 32'h0, 40);
        bus_xfer(B + 32'h08, 32'h0000_0001, 4'b1111, 32'h0, 41);
        src[0] = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1)
                src[0] = 1'b0;
            if (!found && irq_out[0]) begin
                found = 1'b1;
                lat = k;
            end
        end
        check("irq0_within4", 32'(found && lat <= 4), 32'h1);
        eoi[0] = 1'b1;
        @(negedge clk);
        check("eoi0_cyc1", 32'(irq_out[0]), 32'h1);
        @(negedge clk);
        check("eoi0_cyc2", 32'(irq_out[0]), 32'h0);
        eoi[0] = 1'b0;
        waitc(4);
        check("eoi0_stays_low", 32'(irq_out[0]), 32'h0);

        // Edge on bit 3 arriving while its handler is already running.
        bus_xfer(B + 32'h04, 32'h0000_0009, 4'b1111, 32'h0, 50);
        bus_xfer(B + 32'h08, 32'h0000_0009, 4'b1111, 32'h0, 51);
        eoi[3] = 1'b1;
        waitc(2);
        src[3] = 1'b1;
        waitc(5);
        check("irq3_in_handler", 32'(irq_out[3]), 32'h1);
        eoi[3] = 1'b0;
        waitc(3);
        check("irq3_after_eoi", 32'(irq_out[3]), 32'h1);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0000_0008, 52);
        src[3] = 1'b0;

        // FORCE and W1C honour byte lanes.
        bus_xfer(B + 32'h10, 32'h0000_8000, 4'b0010, 32'h0, 60);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0000_8008, 61);
        bus_xfer(B + 32'h00, 32'h0000_8000, 4'b0001, 32'h0, 62);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0000_8008, 63);
        bus_xfer(B + 32'h00, 32'h0000_8000, 4'b0011, 32'h0, 64);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0000_0008, 65);

        // Outside the window: never answered.
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = B + 32'h100;
        bus_if.mem_wstrb = 4'b0000;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus_if.mem_ready)
                seen++;
        end
        bus_if.mem_valid = 1'b0;
        check("out_of_window_ready", 32'(seen), 32'h0);
        waitc(1);

        // Held request: ready toggles 1,0,1,0.
        hold_exp = 4'b0101;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = B + 32'h04;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hold_ready%0d", k), 32'(bus_if.mem_ready), 32'(hold_exp[k]));
            check($sformatf("hold_rdata%0d", k), bus_if.mem_rdata,
                  hold_exp[k] ? 32'h0000_0009 : 32'h0);
        end
        bus_if.mem_valid = 1'b0;
        waitc(1);

        // Reset in the ready cycle drops the transaction immediately.
        bus_if.mem_valid = 1'b1;
        bus_if.mem_addr  = B + 32'h04;
        @(posedge clk);
        #1;
        check("pre_rst_ready", 32'(bus_if.mem_ready), 32'h1);
        rstn = 1'b0;
        #1;
        check("rst_ready_drop", 32'(bus_if.mem_ready), 32'h0);
        check("rst_rdata_drop", bus_if.mem_rdata, 32'h0);
        bus_if.mem_valid = 1'b0;
        waitc(2);
        rstn = 1'b1;
        waitc(3);
        bus_xfer(B + 32'h00, 32'h0, 4'b0000, 32'h0, 70);
        bus_xfer(B + 32'h04, 32'h0, 4'b0000, 32'h0, 71);
        bus_xfer(B + 32'h08, 32'h0, 4'b0000, 32'h0, 72);
        check("post_rst_irq_out", 32'(irq_out), 32'h0);
        check("sb_empty", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
